// File: rtl/vscale_csr_host_arbiter_pkg.sv
// Shared encodings for the CSR host-port arbiter: FSM states and requester ids.
// Also provides the round-robin pointer update applied after each completed transaction.
package vscale_csr_host_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    localparam logic ARB_OWNER_HTIF = 1'b0;
    localparam logic ARB_OWNER_DBG  = 1'b1;

    // After serving one requester, the other gets priority on the next tie.
    function automatic logic next_pri(input logic last_owner);
        return ~last_owner;
    endfunction

endpackage

// File: rtl/vscale_csr_host_arbiter_rr_arb2.sv
// Two-input round-robin grant for the CSR host-port arbiter.
// pri selects the winner only when both inputs are valid.
module vscale_rr_arb2
    import vscale_csr_host_arbiter_pkg::*;
(
    input  logic pri,
    input  logic h_valid,
    input  logic d_valid,
    output logic h_grant,
    output logic d_grant
);

    logic favour_dbg;

    assign favour_dbg = (pri == ARB_OWNER_DBG);
    assign h_grant    = h_valid && (!d_valid || !favour_dbg);
    assign d_grant    = d_valid && (!h_valid ||  favour_dbg);

endmodule

// File: rtl/vscale_csr_host_arbiter.sv
// Serialises HTIF and debug-port PCR requests onto the CSR file's host port.
// One transaction in flight at a time; responses are routed back to the issuing requester.
module vscale_csr_host_arbiter
    import vscale_csr_host_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_csr_busy,

    input  logic              h_req_valid,
    output logic              h_req_ready,
    input  logic              h_req_rw,
    input  logic [ADDR_W-1:0] h_req_addr,
    input  logic [DATA_W-1:0] h_req_data,
    output logic              h_resp_valid,
    input  logic              h_resp_ready,
    output logic [DATA_W-1:0] h_resp_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_rw,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_data,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [DATA_W-1:0] d_resp_data,

    output logic              csr_req_valid,
    input  logic              csr_req_ready,
    output logic              csr_req_rw,
    output logic [ADDR_W-1:0] csr_req_addr,
    output logic [DATA_W-1:0] csr_req_data,
    input  logic              csr_resp_valid,
    output logic              csr_resp_ready,
    input  logic [DATA_W-1:0] csr_resp_data,

    output logic              owner
);

    arb_state_t        state_q, state_d;
    logic              pri_q;
    logic              owner_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic grant_h, grant_d;
    logic h_accept, d_accept, accept;
    logic resp_fire;

    vscale_rr_arb2 u_rr_arb2 (
        .pri     (pri_q),
        .h_valid (h_req_valid),
        .d_valid (d_req_valid),
        .h_grant (grant_h),
        .d_grant (grant_d)
    );

    assign h_accept  = h_req_valid && h_req_ready;
    assign d_accept  = d_req_valid && d_req_ready;
    assign accept    = h_accept || d_accept;
    assign resp_fire = (state_q == ARB_RESP) && csr_resp_valid && csr_resp_ready;

    // The CSR file only ever sees the latched copy, so requesters may change fields after acceptance.
    assign csr_req_rw   = rw_q;
    assign csr_req_addr = addr_q;
    assign csr_req_data = data_q;
    assign owner        = owner_q;

    assign h_resp_data = (owner_q == ARB_OWNER_HTIF) ? csr_resp_data : '0;
    assign d_resp_data = (owner_q == ARB_OWNER_DBG)  ? csr_resp_data : '0;

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        h_req_ready    = 1'b0;
        d_req_ready    = 1'b0;
        csr_req_valid  = 1'b0;
        h_resp_valid   = 1'b0;
        d_resp_valid   = 1'b0;
        csr_resp_ready = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Holding off while the pipeline runs a CSR op keeps host and system writes apart.
                if (!core_csr_busy) begin
                    h_req_ready = grant_h;
                    d_req_ready = grant_d;
                end
                if (accept) begin
                    state_d = ARB_ISSUE;
                end
            end

            ARB_ISSUE: begin
                csr_req_valid = !core_csr_busy;
                if (csr_req_valid && csr_req_ready) begin
                    state_d = ARB_RESP;
                end
            end

            ARB_RESP: begin
                if (owner_q == ARB_OWNER_DBG) begin
                    d_resp_valid   = csr_resp_valid;
                    csr_resp_ready = d_resp_ready;
                end else begin
                    h_resp_valid   = csr_resp_valid;
                    csr_resp_ready = h_resp_ready;
                end
                if (csr_resp_valid && csr_resp_ready) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            pri_q   <= ARB_OWNER_HTIF;
            owner_q <= ARB_OWNER_HTIF;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= d_accept ? ARB_OWNER_DBG : ARB_OWNER_HTIF;
                rw_q    <= d_accept ? d_req_rw   : h_req_rw;
                addr_q  <= d_accept ? d_req_addr : h_req_addr;
                data_q  <= d_accept ? d_req_data : h_req_data;
            end
            if (resp_fire) begin
                pri_q <= next_pri(owner_q);
            end
        end
    end

endmodule

// File: tb/tb_vscale_csr_host_arbiter.sv
// Directed self-checking bench for vscale_csr_host_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_vscale_csr_host_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_csr_busy;
    logic              h_req_valid, h_req_ready, h_req_rw;
    logic [ADDR_W-1:0] h_req_addr;
    logic [DATA_W-1:0] h_req_data;
    logic              h_resp_valid, h_resp_ready;
    logic [DATA_W-1:0] h_resp_data;
    logic              d_req_valid, d_req_ready, d_req_rw;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_data;
    logic              d_resp_valid, d_resp_ready;
    logic [DATA_W-1:0] d_resp_data;
    logic              csr_req_valid, csr_req_ready, csr_req_rw;
    logic [ADDR_W-1:0] csr_req_addr;
    logic [DATA_W-1:0] csr_req_data;
    logic              csr_resp_valid, csr_resp_ready;
    logic [DATA_W-1:0] csr_resp_data;
    logic              owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vscale_csr_host_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .core_csr_busy  (core_csr_busy),
        .h_req_valid    (h_req_valid),
        .h_req_ready    (h_req_ready),
        .h_req_rw       (h_req_rw),
        .h_req_addr     (h_req_addr),
        .h_req_data     (h_req_data),
        .h_resp_valid   (h_resp_valid),
        .h_resp_ready   (h_resp_ready),
        .h_resp_data    (h_resp_data),
        .d_req_valid    (d_req_valid),
        .d_req_ready    (d_req_ready),
        .d_req_rw       (d_req_rw),
        .d_req_addr     (d_req_addr),
        .d_req_data     (d_req_data),
        .d_resp_valid   (d_resp_valid),
        .d_resp_ready   (d_resp_ready),
        .d_resp_data    (d_resp_data),
        .csr_req_valid  (csr_req_valid),
        .csr_req_ready  (csr_req_ready),
        .csr_req_rw     (csr_req_rw),
        .csr_req_addr   (csr_req_addr),
        .csr_req_data   (csr_req_data),
        .csr_resp_valid (csr_resp_valid),
        .csr_resp_ready (csr_resp_ready),
        .csr_resp_data  (csr_resp_data),
        .owner          (owner)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Full transaction starting in IDLE; debug fields are derived from the HTIF ones so the
    // forwarded fields reveal which requester won.
    task automatic run_xact(input string tag, input logic hv, input logic dv, input logic exp_own,
                            input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata);
        logic              e_rw;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        e_rw   = exp_own ? ~rw        : rw;
        e_addr = exp_own ? addr + 12'd1 : addr;
        e_data = exp_own ? ~wdata     : wdata;

        h_req_valid = hv;  h_req_rw = rw;  h_req_addr = addr;          h_req_data = wdata;
        d_req_valid = dv;  d_req_rw = ~rw; d_req_addr = addr + 12'd1;  d_req_data = ~wdata;
        settle();
        check1({tag, ".h_ready"}, h_req_ready, !exp_own);
        check1({tag, ".d_ready"}, d_req_ready, exp_own);
        check1({tag, ".idle_req_valid"}, csr_req_valid, 1'b0);

        tick();
        h_req_valid = 1'b0; d_req_valid = 1'b0;
        h_req_addr = '1; d_req_addr = '1; h_req_data = '0; d_req_data = '0;
        csr_req_ready = 1'b1;
        settle();
        check1({tag, ".issue_valid"}, csr_req_valid, 1'b1);
        check1({tag, ".issue_rw"}, csr_req_rw, e_rw);
        check64({tag, ".issue_addr"}, 64'(csr_req_addr), 64'(e_addr));
        check64({tag, ".issue_data"}, csr_req_data, e_data);
        check1({tag, ".owner"}, owner, exp_own);
        check1({tag, ".issue_h_ready"}, h_req_ready, 1'b0);

        tick();
        csr_req_ready = 1'b0;
        csr_resp_valid = 1'b1; csr_resp_data = rdata;
        h_resp_ready = 1'b1; d_resp_ready = 1'b1;
        settle();
        check1({tag, ".h_resp_valid"}, h_resp_valid, !exp_own);
        check1({tag, ".d_resp_valid"}, d_resp_valid, exp_own);
        check64({tag, ".resp_data"}, exp_own ? d_resp_data : h_resp_data, rdata);
        check1({tag, ".csr_resp_ready"}, csr_resp_ready, 1'b1);

        tick();
        csr_resp_valid = 1'b0; csr_resp_data = '0;
        settle();
        check1({tag, ".back_idle_h"}, h_resp_valid, 1'b0);
        check1({tag, ".back_idle_d"}, d_resp_valid, 1'b0);
        check1({tag, ".back_idle_req"}, csr_req_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset = 1'b1; core_csr_busy = 1'b0;
        h_req_valid = 1'b0; h_req_rw = 1'b0; h_req_addr = '0; h_req_data = '0; h_resp_ready = 1'b0;
        d_req_valid = 1'b0; d_req_rw = 1'b0; d_req_addr = '0; d_req_data = '0; d_resp_ready = 1'b0;
        csr_req_ready = 1'b0; csr_resp_valid = 1'b0; csr_resp_data = '0;

        // Reset state
        tick(); tick();
        settle();
        check1("rst.h_ready", h_req_ready, 1'b0);
        check1("rst.d_ready", d_req_ready, 1'b0);
        check1("rst.csr_req_valid", csr_req_valid, 1'b0);
        check1("rst.csr_resp_ready", csr_resp_ready, 1'b0);
        check1("rst.h_resp_valid", h_resp_valid, 1'b0);
        check1("rst.d_resp_valid", d_resp_valid, 1'b0);
        check1("rst.owner", owner, 1'b0);
        check1("rst.rw", csr_req_rw, 1'b0);
        check64("rst.addr", 64'(csr_req_addr), 64'h0);
        check64("rst.data", csr_req_data, 64'h0);
        reset = 1'b0;
        tick();

        // Both valid from reset: HTIF first, then strict alternation over 8 transactions
        for (int i = 0; i < 8; i++) begin
            run_xact("alt", 1'b1, 1'b1, i[0], i[1], 12'h100 + 12'(i * 16),
                     64'h1000 + 64'(i), 64'hA000 + 64'(i));
        end

        // HTIF-only read of 0x780
        run_xact("h_read", 1'b1, 1'b0, 1'b0, 1'b0, 12'h780, 64'h0, 64'h1234);

        // core_csr_busy held 5 cycles in IDLE, then 5 cycles in ISSUE
        core_csr_busy = 1'b1;
        h_req_valid = 1'b1; h_req_rw = 1'b1; h_req_addr = 12'h300; h_req_data = 64'hAAAA;
        for (int i = 0; i < 5; i++) begin
            settle();
            check1("busy_idle.h_ready", h_req_ready, 1'b0);
            check1("busy_idle.req_valid", csr_req_valid, 1'b0);
            tick();
        end
        core_csr_busy = 1'b0;
        settle();
        check1("busy_idle.release_ready", h_req_ready, 1'b1);
        tick();
        h_req_valid = 1'b0; h_req_addr = 12'h555; h_req_data = 64'h5555;
        core_csr_busy = 1'b1; csr_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check1("busy_issue.req_valid", csr_req_valid, 1'b0);
            tick();
        end
        core_csr_busy = 1'b0;
        settle();
        check1("busy_issue.release_valid", csr_req_valid, 1'b1);
        check1("busy_issue.rw", csr_req_rw, 1'b1);
        check64("busy_issue.addr", 64'(csr_req_addr), 64'h300);
        check64("busy_issue.data", csr_req_data, 64'hAAAA);
        tick();
        csr_req_ready = 1'b0; csr_resp_valid = 1'b1; csr_resp_data = 64'h77; h_resp_ready = 1'b1;
        core_csr_busy = 1'b1;
        settle();
        check1("busy_resp.h_resp_valid", h_resp_valid, 1'b1);
        check1("busy_resp.csr_resp_ready", csr_resp_ready, 1'b1);
        tick();
        core_csr_busy = 1'b0; csr_resp_valid = 1'b0;

        // Debug read with request and response backpressure
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 12'h7A0; d_req_data = 64'h0;
        settle();
        check1("bp.d_ready", d_req_ready, 1'b1);
        tick();
        d_req_valid = 1'b0; d_req_addr = 12'h000;
        csr_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check1("bp.issue_valid", csr_req_valid, 1'b1);
            check64("bp.issue_addr", 64'(csr_req_addr), 64'h7A0);
            tick();
        end
        csr_req_ready = 1'b1;
        tick();
        csr_req_ready = 1'b0;
        csr_resp_valid = 1'b1; csr_resp_data = 64'hBEEF; d_resp_ready = 1'b0; h_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check1("bp.d_resp_valid", d_resp_valid, 1'b1);
            check64("bp.d_resp_data", d_resp_data, 64'hBEEF);
            check1("bp.csr_resp_ready", csr_resp_ready, 1'b0);
            check1("bp.h_resp_valid", h_resp_valid, 1'b0);
            tick();
        end
        d_resp_ready = 1'b1;
        settle();
        check1("bp.csr_resp_ready_release", csr_resp_ready, 1'b1);
        tick();
        csr_resp_valid = 1'b0;
        settle();
        check1("bp.idle_d_resp_valid", d_resp_valid, 1'b0);

        // HTIF transaction moves priority to debug before the reset test
        run_xact("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 64'h0, 64'h42);

        // Debug transaction interrupted by reset while in RESP
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 12'h020;
        tick();
        d_req_valid = 1'b0; csr_req_ready = 1'b1;
        tick();
        csr_req_ready = 1'b0; csr_resp_valid = 1'b1; csr_resp_data = 64'h99; d_resp_ready = 1'b0;
        settle();
        check1("mid_rst.in_resp", d_resp_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check1("mid_rst.d_resp_valid", d_resp_valid, 1'b0);
        check1("mid_rst.h_resp_valid", h_resp_valid, 1'b0);
        check1("mid_rst.csr_req_valid", csr_req_valid, 1'b0);
        check1("mid_rst.csr_resp_ready", csr_resp_ready, 1'b0);
        check1("mid_rst.owner", owner, 1'b0);
        csr_resp_valid = 1'b0;

        // New HTIF write of 0xDEAD to 0x781; both valid shows priority back at HTIF
        run_xact("post_rst", 1'b1, 1'b1, 1'b0, 1'b1, 12'h781, 64'hDEAD, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vscale_csr_host_arbiter.md
# vscale_csr_host_arbiter

Arbitrates two off-core requesters, the HTIF PCR channel and a debug-port channel, onto the single host PCR port of the CSR file. It sits between the HTIF and debug front-ends and the CSR file's `htif_pcr_*` interface. It serialises one transaction at a time, alternates fairly between the requesters, and routes each response back to the requester that issued it. While the core pipeline is executing a CSR instruction, the block holds off requests so that host writes never collide with system writes.

## Interface
Parameters:
- `ADDR_W`, default 12: CSR address width; matches `CSR_ADDR_WIDTH`.
- `DATA_W`, default 64: PCR data width; matches `HTIF_PCR_WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `core_csr_busy`  in  1  core has a CSR command (`cmd[2]`) in the current cycle.
- `h_req_valid`  in  1  HTIF request valid.
- `h_req_ready`  out  1  HTIF request accepted this cycle.
- `h_req_rw`  in  1  HTIF request direction; 1 = write.
- `h_req_addr`  in  ADDR_W  HTIF request address.
- `h_req_data`  in  DATA_W  HTIF write data.
- `h_resp_valid`  out  1  HTIF response valid.
- `h_resp_ready`  in  1  HTIF ready for response.
- `h_resp_data`  out  DATA_W  HTIF response data.
- `d_req_valid`, `d_req_ready`, `d_req_rw`, `d_req_addr`, `d_req_data`, `d_resp_valid`, `d_resp_ready`, `d_resp_data`: debug channel; same directions, widths and meanings as the HTIF channel.
- `csr_req_valid`  out  1  request to CSR file.
- `csr_req_ready`  in  1  CSR file ready to accept.
- `csr_req_rw`  out  1  forwarded request direction.
- `csr_req_addr`  out  ADDR_W  forwarded request address.
- `csr_req_data`  out  DATA_W  forwarded write data.
- `csr_resp_valid`  in  1  CSR file response valid.
- `csr_resp_ready`  out  1  response accepted.
- `csr_resp_data`  in  DATA_W  CSR file response data.
- `owner`  out  1  current/last granted requester; 0 = HTIF, 1 = debug (observability).

## Operation
- State machine with three states:
  - IDLE: no transaction in flight.
  - ISSUE: latched request presented to the CSR file.
  - RESP: waiting for, then forwarding, the response.
- Priority pointer `pri`: 0 favours HTIF, 1 favours debug. Reset value 0.
- Grant in IDLE when `!core_csr_busy`:
  - Only one requester valid: that requester is granted.
  - Both valid: `pri` picks the winner.
- Acceptance: the granted requester's `*_req_ready` is 1 combinationally. Both ready outputs are 0 outside IDLE, or when `core_csr_busy` is high.
- On accept (`valid && ready`): latch rw, addr and data into internal registers, set `owner`, and go to ISSUE.
- ISSUE:
  - `csr_req_valid` = `!core_csr_busy`; `csr_req_*` fields are driven from the latched registers only.
  - On `csr_req_valid && csr_req_ready`, go to RESP.
- RESP:
  - The owner's `*_resp_valid` = `csr_resp_valid` and `*_resp_data` = `csr_resp_data`. The non-owner's resp_valid = 0.
  - `csr_resp_ready` = owner's resp_ready.
  - On the response handshake: go to IDLE and set `pri` to `~owner`.
- Writes and reads follow the same flow; both return exactly one response.

## Timing
- Reset values:
  - State = IDLE, `pri` = 0, `owner` = 0, latched fields = 0.
  - All `*_ready`, `*_resp_valid` and `csr_req_valid` = 0.
  - `csr_resp_ready` = 0, because the owner's resp_ready is not passed through outside RESP.
- Minimum latency, requester accept to requester response: 2 cycles, with one cycle each in ISSUE and RESP when the CSR file responds the cycle after accepting.
- Back-to-back: IDLE is always visited for one cycle between transactions. Throughput is at most one transaction per 3 cycles.
- `core_csr_busy` stalls IDLE and ISSUE indefinitely. It has no effect in RESP.
- Requester fields may change after acceptance without effect.
- Reset mid-transaction returns to IDLE immediately. The in-flight response is dropped and the requester is not notified.
- A requester deasserting valid before ready is legal; no grant occurs.

## Structure
- Shared package/header (`vscale_ctrl_constants.vh`):
  - state encodings `ARB_IDLE` = 0, `ARB_ISSUE` = 1, `ARB_RESP` = 2, width 2;
  - owner encodings `ARB_OWNER_HTIF` = 0, `ARB_OWNER_DBG` = 1.
- One natural sub-module: `vscale_rr_arb2`, a two-input round-robin grant computed from the pointer and the two valids. Everything else is inline.

## Test plan
- HTIF only: read of addr 0x780 → `csr_req_valid` 1 cycle after accept with addr 0x780, rw = 0. CSR returns 0x1234 → `h_resp_data` = 0x1234 and `d_resp_valid` stays 0.
- Both valid from reset:
  - HTIF granted first; debug granted second.
  - Third simultaneous pair → HTIF granted (alternation verified over 8 transactions, 4 each).
- `core_csr_busy` held 5 cycles in IDLE and in ISSUE → no ready and no `csr_req_valid` during busy. The transaction completes after busy drops, with fields unchanged.
- Backpressure:
  - `csr_req_ready` = 0 for 3 cycles → remains in ISSUE with stable fields.
  - `d_resp_ready` = 0 for 4 cycles → `d_resp_valid` held and `csr_resp_ready` = 0.
- Reset asserted in RESP:
  - Next cycle all valids = 0, state = IDLE, `pri` = 0.
  - A new HTIF write of 0xDEAD to 0x781 completes normally.
